code_pulse_generator: RTL

Responder side of the sequencer's GEN / SIGNAL_GEN_OVER handshake. On each GEN request it latches the current code word and pulse parameters, then produces a gated, chip-coded transmit pulse: a TX gate, a per-chip phase bit, and a chip strobe that drive the AD9911 phase/amplitude control path. When the pulse completes it raises SIGNAL_GEN_OVER and holds it until the sequencer withdraws GEN.

---
 rtl/code_pulse_generator_if.sv | 28 ++
 rtl/code_pulse_generator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/code_pulse_generator_if.sv
// Sequencer <-> pulse generator handshake and pulse-parameter bundle.
// master = sequencer side, slave = code_pulse_generator.
interface code_pulse_generator_if #(
   parameter int CHIP_MAX = 32
);
   logic                PRE_GEN;
   logic                GEN;
   logic                RF_OUTPUT_EN;
   logic [CHIP_MAX-1:0] CODE;
   logic [15:0]         CODE_LEN;
   logic [15:0]         CODE_DURATION;
   logic [15:0]         PULSE_LEN;
   logic                SIGNAL_GEN_OVER;
   logic                TX_PREP;
   logic                TX_GATE;
   logic                PHASE_BIT;
   logic                CHIP_STB;

   modport master (
      output PRE_GEN, GEN, RF_OUTPUT_EN, CODE, CODE_LEN, CODE_DURATION, PULSE_LEN,
      input  SIGNAL_GEN_OVER, TX_PREP, TX_GATE, PHASE_BIT, CHIP_STB
   );

   modport slave (
      input  PRE_GEN, GEN, RF_OUTPUT_EN, CODE, CODE_LEN, CODE_DURATION, PULSE_LEN,
      output SIGNAL_GEN_OVER, TX_PREP, TX_GATE, PHASE_BIT, CHIP_STB
   );
endinterface

// File: rtl/code_pulse_generator.sv
// Responder to the sequencer GEN / SIGNAL_GEN_OVER handshake: emits a gated,
// chip-coded transmit pulse (gate, per-chip phase bit, chip strobe).
module code_pulse_generator #(
   parameter int CHIP_MAX = 32
) (
   input logic                    CLOCK_10M,
   input logic                    RESET_N,
   code_pulse_generator_if.slave  bus
);
   localparam int SEL_W = $clog2(CHIP_MAX);

   typedef enum logic [1:0] {WAIT_LOW, IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [CHIP_MAX-1:0] code_q;
   logic [5:0]          len_q;
   logic [5:0]          idx;
   logic [15:0]         dur_q;
   logic [15:0]         plen_q;
   logic [15:0]         pcnt;
   logic [15:0]         ccnt;
   logic                gate_en;

   logic [5:0]          len_in;
   logic [15:0]         dur_in;
   logic [5:0]          idx_nxt;
   logic                chip_end;
   logic                nxt_valid;

   always_comb begin
      len_in = bus.CODE_LEN[5:0];
      if (bus.CODE_LEN == 16'd0)
         len_in = 6'd1;
      else if (bus.CODE_LEN > 16'(CHIP_MAX))
         len_in = 6'(CHIP_MAX);
      dur_in    = (bus.CODE_DURATION == 16'd0) ? 16'd1 : bus.CODE_DURATION;
      idx_nxt   = idx + 6'd1;
      chip_end  = (ccnt == dur_q - 16'd1);
      nxt_valid = (idx_nxt < len_q);
   end

   always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
      if (!RESET_N) begin
         state               <= WAIT_LOW;
         code_q              <= '0;
         len_q               <= '0;
         idx                 <= '0;
         dur_q               <= '0;
         plen_q              <= '0;
         pcnt                <= '0;
         ccnt                <= '0;
         gate_en             <= 1'b0;
         bus.SIGNAL_GEN_OVER <= 1'b0;
         bus.TX_PREP         <= 1'b0;
         bus.TX_GATE         <= 1'b0;
         bus.PHASE_BIT       <= 1'b0;
         bus.CHIP_STB        <= 1'b0;
      end else begin
         bus.TX_PREP <= bus.PRE_GEN & bus.RF_OUTPUT_EN;
         case (state)
            // A fresh request needs GEN low first, so a level held over reset is ignored.
            WAIT_LOW: begin
               if (!bus.GEN) state <= IDLE;
            end
            IDLE: begin
               if (bus.GEN) begin
                  code_q  <= bus.CODE;
                  len_q   <= len_in;
                  dur_q   <= dur_in;
                  plen_q  <= bus.PULSE_LEN;
                  gate_en <= bus.RF_OUTPUT_EN;
                  pcnt    <= '0;
                  ccnt    <= '0;
                  idx     <= '0;
                  if (bus.PULSE_LEN == 16'd0) begin
                     state <= DONE;
                  end else begin
                     state         <= RUN;
                     bus.TX_GATE   <= bus.RF_OUTPUT_EN;
                     bus.PHASE_BIT <= bus.CODE[0];
                     bus.CHIP_STB  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!bus.GEN) begin
                  state         <= IDLE;
                  bus.TX_GATE   <= 1'b0;
                  bus.PHASE_BIT <= 1'b0;
                  bus.CHIP_STB  <= 1'b0;
               end else if (pcnt == plen_q - 16'd1) begin
                  state               <= DONE;
                  bus.SIGNAL_GEN_OVER <= 1'b1;
                  bus.TX_GATE         <= 1'b0;
                  bus.PHASE_BIT       <= 1'b0;
                  bus.CHIP_STB        <= 1'b0;
               end else begin
                  pcnt        <= pcnt + 16'd1;
                  bus.TX_GATE <= gate_en;
                  if (chip_end) begin
                     ccnt <= '0;
                     // idx parks at len_q so long tails cannot wrap it
                     if (idx < len_q) idx <= idx_nxt;
                     bus.PHASE_BIT <= nxt_valid ? code_q[idx_nxt[SEL_W-1:0]] : 1'b0;
                     bus.CHIP_STB  <= nxt_valid;
                  end else begin
                     ccnt         <= ccnt + 16'd1;
                     bus.CHIP_STB <= 1'b0;
                  end
               end
            end
            DONE: begin
               if (!bus.GEN) begin
                  state               <= IDLE;
                  bus.SIGNAL_GEN_OVER <= 1'b0;
               end else begin
                  bus.SIGNAL_GEN_OVER <= 1'b1;
               end
            end
            default: state <= WAIT_LOW;
         endcase
      end
   end
endmodule
